mbe_radix4_seq_mult: RTL and testbench

//  Iterative signed multiplier using radix-4 Modified Booth Encoding (MBE).

---
 rtl/mbe_radix4_seq_mult.sv | 186 ++++++++++++++++++
 tb/tb_mbe_radix4_seq_mult.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbe_radix4_seq_mult.sv
// mbe_radix4_seq_mult: iterative signed multiplier using radix-4 Modified
// Booth Encoding. One Booth digit is encoded and one partial product
// generated per cycle. A row of full_adder cells compresses it into a
// carry-save accumulator, and a final carry-propagate add resolves the product.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset, aborts any operation
//   start  request a multiply, sampled only in IDLE
//   a, b   signed N-bit multiplicand / multiplier, captured on accepted start
//   busy   high while in RUN or FINAL
//   done   one-cycle pulse, p valid in that cycle
//   p      signed 2N-bit product, held until the next accepted start
//
// state   | meaning
// S_IDLE  | waiting for start, p holds last result
// S_RUN   | one Booth digit per cycle, i = 0 .. N/2-1
// S_FINAL | carry-propagate add of sum/carry into p

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module mbe_radix4_seq_mult #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int W    = 2 * N;
    localparam int HALF = N / 2;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N:0]    b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [W-1:0]  carry_q, carry_d;
    logic [W-1:0]  inj_q, inj_d;
    logic [IW-1:0] i_q, i_d;
    logic [W-1:0]  p_q, p_d;
    logic          done_q, done_d;

    logic [IW:0]   shamt;
    logic [2:0]    trip;
    logic [N:0]    mag;
    logic          neg;
    logic [N:0]    pp_base;
    logic [W-1:0]  pp_ext;
    logic [W-1:0]  pp_row;
    logic [W-1:0]  inj_new;
    logic [W-1:0]  carry_in;
    logic [W-1:0]  fa_s;
    logic [W-1:0]  fa_c;

    assign shamt = {i_q, 1'b0};
    // b_q holds {b, 1'b0}, so bit 2i of b_q is Booth bit B[2i-1].
    assign trip  = 3'(b_q >> shamt);

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (trip)
            3'b001, 3'b010: mag = {a_q[N-1], a_q};
            3'b011:         mag = {a_q, 1'b0};
            3'b100: begin
                mag = {a_q, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {a_q[N-1], a_q};
                neg = 1'b1;
            end
            default: begin
                mag = '0;
                neg = 1'b0;
            end
        endcase
    end

    assign pp_base = neg ? ~mag : mag;
    assign pp_ext  = {{(W-N-1){pp_base[N]}}, pp_base};

    // The +1 that completes a negation cannot go into this cycle's row at bit
    // 2i without colliding with live bits, so it is parked in inj_q and
    // folded into the next row, whose bits below 2i+2 are guaranteed zero.
    // The last digit's +1 is absorbed by the final add.
    assign pp_row   = (pp_ext << shamt) | inj_q;
    assign inj_new  = neg ? (W'(1) << shamt) : '0;
    assign carry_in = carry_q << 1;

    for (genvar g = 0; g < W; g++) begin : g_fa_row
        full_adder u_fa (
            .a    (sum_q[g]),
            .b    (carry_in[g]),
            .cin  (pp_row[g]),
            .s    (fa_s[g]),
            .cout (fa_c[g])
        );
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        inj_d   = inj_q;
        i_d     = i_q;
        p_d     = p_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = {b, 1'b0};
                    sum_d   = '0;
                    carry_d = '0;
                    inj_d   = '0;
                    i_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = fa_s;
                carry_d = fa_c;
                inj_d   = inj_new;
                i_d     = i_q + 1'b1;
                if (i_q == I_LAST) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                p_d     = sum_q + carry_in + inj_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            inj_q   <= '0;
            i_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            inj_q   <= inj_d;
            i_q     <= i_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_mbe_radix4_seq_mult.sv
module tb_mbe_radix4_seq_mult;
    localparam int N   = 8;
    localparam int LAT = N / 2 + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    always #5 clk = ~clk;

    mbe_radix4_seq_mult #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] p;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[10];

    int   tests = 0;
    int   fails = 0;
    int   ndone = 0;
    int   bcnt  = 0;
    bit   abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard / protocol monitor
    always @(negedge clk) begin
        if (rst) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
        end else if (bcnt != 0) begin
            if (!abort) chk("busy_len", 32'(bcnt), 32'(N / 2 + 1));
            bcnt = 0;
        end
        if (done) begin
            ndone++;
            chk("done_busy_excl", 32'(busy), 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: p=%0h with no pending op (cycle %0d)", p, cyc);
            end else begin
                e = sb.pop_front();
                chk("product", 32'(p), 32'(e.p));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; waits for IDLE, issues one op, returns one cycle later.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] ep);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
        end
        a     = ia;
        b     = ib;
        start = 1'b1;
        sb.push_back('{ep, cyc + LAT});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic signed [7:0] ra;
        logic signed [7:0] rb;
        int prod;
        int c0;
        int nd0;

        vecs[0] = '{8'h03, 8'h05, 16'h000F};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[4] = '{8'h00, 8'hFF, 16'h0000};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{8'h80, 8'h01, 16'hFF80};
        vecs[7] = '{8'h01, 8'h80, 16'hFF80};
        vecs[8] = '{8'h07, 8'hFE, 16'hFFF2};
        vecs[9] = '{8'hAB, 8'h56, 16'hE372};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p", 32'(p), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p);
        end
        drain();

        // Random signed pairs against the bench's own product
        for (int i = 0; i < 200; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            prod = int'(ra) * int'(rb);
            run_op(ra, rb, 16'(prod));
        end
        drain();

        // start pulsed mid-RUN with different operands is ignored
        nd0 = ndone;
        run_op(8'h09, 8'hFD, 16'hFFE5);
        @(negedge clk);
        a     = 8'd100;
        b     = 8'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("midrun_one_done", 32'(ndone - nd0), 32'd1);

        // start held high through done: second op accepted in the done cycle
        c0    = cyc;
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        sb.push_back('{16'h000F, c0 + LAT});
        @(negedge clk);
        a = 8'd7;
        b = 8'hFE;
        sb.push_back('{16'hFFF2, c0 + 2 * LAT});
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Synchronous reset mid-RUN aborts without a done pulse
        nd0   = ndone;
        a     = 8'd5;
        b     = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p", 32'(p), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        run_op(8'd6, 8'd7, 16'h002A);
        drain();
        chk("abort_one_done", 32'(ndone - nd0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
